uart_rx_periph: RTL and testbench
=================================

# uart_rx_periph

APB-slave UART receive peripheral: deserialises the `rx` pin using 16x oversampling and buffers received bytes in an internal FIFO. Software drains the FIFO over APB. It is the receive-side companion of the APB UART transmit peripheral and shares the same APB bus, register style and baud tick rate.

## Interface
- `FIFO_AW`, default 2: FIFO address width; depth = 2**FIFO_AW.
- `TICK_DIV`, default 10: PCLK cycles per oversample tick (16 ticks per bit).
- `PCLK` in 1: clock.
- `PRESET` in 1: reset, asynchronous, active-high.
- `PADDR` in 4: register byte address; `PADDR[3:2]` selects the register.
- `PWDATA` in 32: write data.
- `PWRITE` in 1: 1 = write.
- `PENABLE` in 1: APB access phase.
- `PSEL` in 1: slave select.
- `PRDATA` out 32: read data. Registered; reset 0.
- `PREADY` out 1: transfer complete. Registered; reset 0.
- `rx` in 1: serial input, asynchronous, idle high.
- `rx_irq` out 1: `CTRL.en & ~empty`, registered; reset 0.

## Operation
- Registers:
  - `0x0 STATUS` (R/W1C): bit0 empty, bit1 full, bit2 overrun (sticky), bit3 frame error (sticky), bit4 parity error (sticky). Writing 1 to bit2/3/4 clears that bit. Bits 0/1 are read-only.
  - `0x4 DATA` (RO): `{24'b0, byte}`. A read pops the FIFO. A read when empty returns 0 and does not pop.
  - `0x8 CTRL` (RW): bit0 `en`, reset 0. Reads return `{31'b0, en}`.
  - `0xC`: reads 0; writes are ignored.
- `rx` passes through a 2-flop synchroniser with flops reset to 1. All receiver logic uses the synchronised value.
- Tick counter: wraps at `TICK_DIV-1` and emits a 1-cycle tick. It runs continuously from reset.
- Receiver FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
  - IDLE -> START: `en` and synchronised rx = 0.
  - START: counts 8 ticks, then resamples. If rx = 1 (false start), go to IDLE. If rx = 0, clear the tick count and go to DATA.
  - DATA: samples every 16 ticks, at mid-bit. Bits are shifted in LSB first. After 8 bits, go to PARITY when that state is compiled in, otherwise to STOP.
  - STOP: samples after 16 ticks.
    - rx = 1: push the byte and go to IDLE.
    - rx = 0: set frame error, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH -> IDLE when rx = 1.
- Clearing `en` mid-frame forces IDLE on the next cycle. The partial byte is discarded.
- Push when full: the byte is dropped and overrun is set. If push and pop happen in the same cycle while full, both take effect and overrun is not set.
- Push and pop in the same cycle while empty: the pop does nothing and the push succeeds.

## Timing
- APB: the access phase is first seen in cycle N (`PSEL & PENABLE & ~PREADY`). In cycle N+1, `PREADY` = 1 and `PRDATA` is valid.
  - `PREADY` returns to 0 in the cycle after `PSEL & PENABLE` drops. Every transfer therefore has one wait state.
  - Register writes and the DATA pop happen in cycle N only, so there is exactly one pop per transfer.
  - `PRDATA` holds its last value when no read is in progress.
- Byte latency: the FIFO push occurs in the cycle after the stop-bit sample tick. Empty falls and `rx_irq` rises 1 cycle after the push.
- STATUS reflects FIFO flags with a 1-cycle register delay.
- Mid-operation `PRESET`: all state returns to reset values immediately, the FIFO becomes empty, and the FSM goes to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is present and samples one even-parity bit after DATA.
  - On a mismatch, STATUS bit4 is set, but the byte is still pushed.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state is absent and the frame is 8N1.
  - STATUS bit4 always reads 0, and a W1C to it has no effect.

## Structure
- Package `uart_rx_pkg` holds:
  - the `rx_state_e` enum;
  - the register offsets `REG_STATUS/REG_DATA/REG_CTRL`;
  - the status bit indices;
  - `OVERSAMPLE = 16`.
- Sub-module `uart_rx_fifo`: a synchronous FIFO with wr_en/rd_en, full/empty and combinational read data, parameterised by `FIFO_AW`.
- Tick generator, synchroniser, FSM and APB slave logic are all in the top level.

## Test plan
Bench uses `TICK_DIV`=10, so 1 bit = 160 PCLK. Parity is disabled except where stated.
- Set `CTRL.en`=1, send 0xA5 8N1 -> `rx_irq` rises, STATUS=0x0, DATA read returns 0x000000A5, then STATUS=0x1.
- Send 5 bytes 0x01..0x05 with no reads -> STATUS bit1=1, bit2=1; four reads return 0x01..0x04 and then STATUS bit0=1.
- Hold the stop bit low for byte 0x3C -> STATUS bit3=1 and the FIFO stays empty; writing 0x8 to STATUS clears bit3.
- Send a 3-tick low glitch (30 PCLK) on `rx` -> no push and the FSM returns to IDLE.
- Read DATA while empty -> `PRDATA`=0, `PREADY` asserted at cycle N+1, flags unchanged.
- With `UART_RX_PARITY_EN`, send 0x07 with a wrong parity bit (0) -> byte 0x07 is pushed and STATUS bit4=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the APB UART receive peripheral.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FE    = 3;
  localparam int STAT_PE    = 4;

  localparam int OVERSAMPLE = 16;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received data; combinational read data, depth 2**AW.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  input  logic       rd_en,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a write while full is allowed then.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_periph.sv
// APB UART receiver: 16x oversampled rx, byte FIFO, W1C status, rx_irq.
// Optional even-parity bit when UART_RX_PARITY_EN is defined (default 8N1).
module uart_rx_periph
  import uart_rx_pkg::*;
#(
  parameter int FIFO_AW  = 2,
  parameter int TICK_DIV = 10
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] OS_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

  logic          sync1_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  rx_state_e     state_q, state_d;
  logic [3:0]    os_cnt_q, os_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          en_q, en_d;
  logic          ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic          empty_q, full_q;
  logic [31:0]   prdata_q, prdata_d;
  logic          pready_q, pready_d;
  logic          irq_q, irq_d;
  logic          frame_set, par_set;
  logic          access, wr_acc, rd_acc, pop;
  logic [1:0]    reg_sel;
  logic [4:0]    status;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:5]};

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign rx_irq = irq_q;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // PREADY blocks a second access phase, so each transfer acts exactly once.
  assign access  = PSEL & PENABLE & ~pready_q;
  assign wr_acc  = access & PWRITE;
  assign rd_acc  = access & ~PWRITE;
  assign reg_sel = PADDR[3:2];
  assign pop     = rd_acc & (reg_sel == REG_DATA) & ~fifo_empty;

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .wr_en (push_q),
    .wdata (shift_q),
    .rd_en (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    if (!en_d) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          if (!rx_s_q) state_d = ST_START;
        end
        ST_START: if (tick) begin
          if (os_cnt_q == OS_HALF) begin
            os_cnt_d = '0;
            state_d  = rx_s_q ? ST_IDLE : ST_DATA;
          end else os_cnt_d = os_cnt_q + 4'd1;
        end
        ST_DATA: if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            shift_d  = {rx_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else bit_cnt_d = bit_cnt_q + 3'd1;
          end else os_cnt_d = os_cnt_q + 4'd1;
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            par_set  = (rx_s_q != even_parity(shift_q));
            state_d  = ST_STOP;
          end else os_cnt_d = os_cnt_q + 4'd1;
        end
`endif
        ST_STOP: if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            push_d    = rx_s_q;
            frame_set = ~rx_s_q;
            state_d   = rx_s_q ? ST_IDLE : ST_WAIT_HIGH;
          end else os_cnt_d = os_cnt_q + 4'd1;
        end
        ST_WAIT_HIGH: if (rx_s_q) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status             = '0;
    status[STAT_EMPTY] = empty_q;
    status[STAT_FULL]  = full_q;
    status[STAT_OVR]   = ovr_q;
    status[STAT_FE]    = fe_q;
    status[STAT_PE]    = pe_q;

    en_d  = en_q;
    ovr_d = ovr_q;
    fe_d  = fe_q;
    pe_d  = pe_q;
    if (wr_acc && reg_sel == REG_CTRL) en_d = PWDATA[0];
    if (wr_acc && reg_sel == REG_STATUS) begin
      if (PWDATA[STAT_OVR]) ovr_d = 1'b0;
      if (PWDATA[STAT_FE])  fe_d  = 1'b0;
      if (PWDATA[STAT_PE])  pe_d  = 1'b0;
    end
    // New events win over a simultaneous clear.
    if (push_q && fifo_full && !pop) ovr_d = 1'b1;
    if (frame_set) fe_d = 1'b1;
    if (par_set)   pe_d = 1'b1;

    pready_d = PSEL & PENABLE;
    prdata_d = prdata_q;
    if (rd_acc) begin
      case (reg_sel)
        REG_STATUS: prdata_d = {27'b0, status};
        REG_DATA:   prdata_d = fifo_empty ? 32'b0 : {24'b0, fifo_rdata};
        REG_CTRL:   prdata_d = {31'b0, en_q};
        default:    prdata_d = 32'b0;
      endcase
    end
    irq_d = en_q & ~fifo_empty;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= ST_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      en_q       <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      en_q       <= en_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      empty_q    <= fifo_empty;
      full_q     <= fifo_full;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph: register table plus serial-frame sequences.
module tb_uart_rx_periph;
  import uart_rx_pkg::*;

  localparam int BIT = 160;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        rx = 1'b1;
  logic        rx_irq;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_periph #(.FIFO_AW(2), .TICK_DIV(10)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .rx      (rx),
    .rx_irq  (rx_irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        chk;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output int lat);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (!PREADY && lat < 8);
    rdata = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    apb(1'b0, addr, 32'h0, d, lat);
    check(name, d, exp);
    check({name, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wr_reg(input string name, input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] d;
    int lat;
    apb(1'b1, addr, data, d, lat);
    check({name, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic par_ok);
    @(negedge PCLK);
    rx = 1'b0;
    repeat (BIT) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge PCLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_ok ? (^b) : ~(^b);
    repeat (BIT) @(negedge PCLK);
`endif
    rx = stop_lvl;
    repeat (BIT) @(negedge PCLK);
    rx = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'h0,        32'h1, 1'b1, "status_rst"};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,        32'h0, 1'b1, "ctrl_rst"};
    vecs[2]  = '{1'b0, 4'hC, 32'h0,        32'h0, 1'b1, "reserved_rd"};
    vecs[3]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h0, 1'b0, "reserved_wr"};
    vecs[4]  = '{1'b0, 4'hC, 32'h0,        32'h0, 1'b1, "reserved_rd2"};
    vecs[5]  = '{1'b0, 4'h4, 32'h0,        32'h0, 1'b1, "data_empty"};
    vecs[6]  = '{1'b0, 4'h0, 32'h0,        32'h1, 1'b1, "status_after_empty_rd"};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000001F, 32'h0, 1'b0, "status_w1c_all"};
    vecs[8]  = '{1'b0, 4'h0, 32'h0,        32'h1, 1'b1, "status_ro_bits"};
    vecs[9]  = '{1'b1, 4'h8, 32'hFFFFFFFF, 32'h0, 1'b0, "ctrl_wr"};
    vecs[10] = '{1'b0, 4'h8, 32'h0,        32'h1, 1'b1, "ctrl_rd"};

    repeat (3) @(negedge PCLK);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", 32'(PREADY), 32'h0);
    check("rst_irq", 32'(rx_irq), 32'h0);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);

    for (int i = 0; i < 11; i++) begin
      logic [31:0] d;
      int lat;
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, lat);
      if (vecs[i].chk) check(vecs[i].name, d, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
    end
    check("irq_empty_en", 32'(rx_irq), 32'h0);

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5_irq", 32'(rx_irq), 32'h1);
    rd_check("a5_status", 4'h0, 32'h0);
    rd_check("a5_data", 4'h4, 32'h000000A5);
    check("a5_irq_drop", 32'(rx_irq), 32'h0);
    rd_check("a5_status_empty", 4'h0, 32'h1);

    // Overflow: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
    check("ovr_irq", 32'(rx_irq), 32'h1);
    rd_check("ovr_status", 4'h0, 32'h6);
    for (int i = 1; i <= 4; i++) rd_check($sformatf("ovr_data%0d", i), 4'h4, 32'(i));
    rd_check("ovr_status_drained", 4'h0, 32'h5);
    wr_reg("ovr_clr", 4'h0, 32'h4);
    rd_check("ovr_status_clr", 4'h0, 32'h1);

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge PCLK);
    check("fe_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("fe_irq", 32'(rx_irq), 32'h0);
    rd_check("fe_status", 4'h0, 32'h9);
    wr_reg("fe_clr", 4'h0, 32'h8);
    rd_check("fe_status_clr", 4'h0, 32'h1);

    // Glitch shorter than half a bit
    @(negedge PCLK);
    rx = 1'b0;
    repeat (30) @(negedge PCLK);
    rx = 1'b1;
    repeat (300) @(negedge PCLK);
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("glitch_irq", 32'(rx_irq), 32'h0);
    rd_check("glitch_status", 4'h0, 32'h1);

    // Disable mid-frame
    fork
      send_frame(8'h00, 1'b1, 1'b1);
      begin
        repeat (500) @(negedge PCLK);
        wr_reg("dis_ctrl", 4'h8, 32'h0);
        check("dis_state", 32'(dut.state_q), 32'(ST_IDLE));
      end
    join
    repeat (20) @(negedge PCLK);
    wr_reg("reen_ctrl", 4'h8, 32'h1);
    repeat (20) @(negedge PCLK);
    rd_check("dis_status", 4'h0, 32'h1);
    check("dis_irq", 32'(rx_irq), 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    rd_check("par_status", 4'h0, 32'h10);
    rd_check("par_data", 4'h4, 32'h07);
    rd_check("par_status_sticky", 4'h0, 32'h11);
    wr_reg("par_clr", 4'h0, 32'h10);
    rd_check("par_status_clr", 4'h0, 32'h1);
`endif

    // Reset while a byte is buffered
    send_frame(8'h55, 1'b1, 1'b1);
    check("prerst_irq", 32'(rx_irq), 32'h1);
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    check("midrst_irq", 32'(rx_irq), 32'h0);
    check("midrst_pready", 32'(PREADY), 32'h0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    rd_check("midrst_status", 4'h0, 32'h1);
    rd_check("midrst_ctrl", 4'h8, 32'h0);
    rd_check("midrst_data", 4'h4, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
